// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control slice: FSM states, opcode/mux-select
// order and the settle-counter width.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_D0 = 2'b00;
  localparam logic [1:0] OP_D1 = 2'b01;
  localparam logic [1:0] OP_D2 = 2'b10;
  localparam logic [1:0] OP_D3 = 2'b11;

  localparam int SETTLE_W = 4;

endpackage

// File: rtl/alu_op_sequencer.sv
// Issues one command to the ALU result mux, waits SETTLE cycles, captures the
// mux output with zero/negative flags and hands it back; supports chaining.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int W      = 8,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic         cmd_acc,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   mux_sel,
  input  logic [W-1:0] mux_y,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_zero,
  output logic         res_neg,
  output logic         busy
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  state_t              state_r;
  logic [SETTLE_W-1:0] cnt_r;
  logic [W-1:0]        acc_r;

  // Handshake and status are pure state decodes so they never loop back
  // through the upstream/downstream valid signals.
  assign cmd_ready = (state_r == ST_IDLE);
  assign res_valid = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);

  // Command sequencing FSM: operand launch, settle count, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      acc_r    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      mux_sel  <= 2'b00;
      res_data <= '0;
      res_zero <= 1'b0;
      res_neg  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a   <= cmd_acc ? acc_r : cmd_a;
            alu_b   <= cmd_b;
            mux_sel <= cmd_op;
            cnt_r   <= SETTLE_LOAD;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_r != {SETTLE_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(SETTLE_W-1){1'b0}}, 1'b1};
          end else begin
            res_data <= mux_y;
            acc_r    <= mux_y;
            res_zero <= (mux_y == {W{1'b0}});
            res_neg  <= mux_y[W-1];
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a SETTLE=1 instance for handshake,
// flag and chaining behaviour, and a SETTLE=3 instance for settle timing.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk;
  logic rst_n;

  logic       cmd_valid, cmd_ready, cmd_acc, res_valid, res_ready;
  logic [1:0] cmd_op, mux_sel;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, mux_y, res_data;
  logic       res_zero, res_neg, busy;
  logic [7:0] tbl [4];

  logic       cmd_valid3, cmd_ready3, cmd_acc3, res_valid3, res_ready3;
  logic [1:0] cmd_op3, mux_sel3;
  logic [7:0] cmd_a3, cmd_b3, alu_a3, alu_b3, mux_y3, res_data3;
  logic       res_zero3, res_neg3, busy3;
  logic [7:0] tbl3 [4];

  int n_tests = 0;
  int n_fail  = 0;

  alu_op_sequencer #(.W(8), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_acc(cmd_acc), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .mux_sel(mux_sel), .mux_y(mux_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_neg(res_neg), .busy(busy)
  );

  alu_op_sequencer #(.W(8), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
    .cmd_acc(cmd_acc3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .alu_a(alu_a3), .alu_b(alu_b3), .mux_sel(mux_sel3), .mux_y(mux_y3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
    .res_zero(res_zero3), .res_neg(res_neg3), .busy(busy3)
  );

  // Behavioural stand-in for the 4:1 result mux.
  always_comb mux_y  = tbl[mux_sel];
  always_comb mux_y3 = tbl3[mux_sel3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_acc = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00;
    res_ready = 1'b1;
    cmd_valid3 = 1'b0; cmd_op3 = 2'b00; cmd_acc3 = 1'b0; cmd_a3 = 8'h00; cmd_b3 = 8'h00;
    res_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tbl[i]  = 8'hEE;
      tbl3[i] = 8'hEE;
    end

    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_mux_sel",   32'(mux_sel),   32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_alu_b",     32'(alu_b),     32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);

    // Basic op 2 with immediate acceptance of the result.
    tbl[2] = 8'h46;
    cmd_valid = 1'b1; cmd_op = OP_D2; cmd_a = 8'h12; cmd_b = 8'h34; cmd_acc = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("b_mux_sel",   32'(mux_sel),   32'd2);
    check("b_alu_a",     32'(alu_a),     32'h12);
    check("b_alu_b",     32'(alu_b),     32'h34);
    check("b_busy",      32'(busy),      32'd1);
    check("b_cmd_ready", 32'(cmd_ready), 32'd0);
    check("b_vld_early", 32'(res_valid), 32'd0);
    tick();
    check("b_res_valid", 32'(res_valid), 32'd1);
    check("b_res_data",  32'(res_data),  32'h46);
    check("b_zero",      32'(res_zero),  32'd0);
    check("b_neg",       32'(res_neg),   32'd0);
    tick();
    check("b_vld_drop",  32'(res_valid), 32'd0);
    check("b_ready_back", 32'(cmd_ready), 32'd1);

    // Backpressure: result held, stray command ignored.
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmd_valid = 1'b1; cmd_op = OP_D1; cmd_a = 8'hAA; cmd_b = 8'hBB;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_data",  32'(res_data),  32'h46);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    check("bp_mux_hold", 32'(mux_sel), 32'd2);
    check("bp_a_hold",   32'(alu_a),   32'h12);
    res_ready = 1'b1;
    tick();
    check("bp_release",  32'(res_valid), 32'd0);

    // Negative result, then chained command using it as operand A.
    tbl[3] = 8'h80;
    cmd_valid = 1'b1; cmd_op = OP_D3; cmd_a = 8'h01; cmd_b = 8'h02; cmd_acc = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("n_res_data", 32'(res_data), 32'h80);
    check("n_neg",      32'(res_neg),  32'd1);
    check("n_zero",     32'(res_zero), 32'd0);
    tick();
    tbl[0] = 8'h5A;
    cmd_valid = 1'b1; cmd_op = OP_D0; cmd_a = 8'hFF; cmd_b = 8'h03; cmd_acc = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_acc = 1'b0;
    check("acc_alu_a",  32'(alu_a),   32'h80);
    check("acc_mux_sel", 32'(mux_sel), 32'd0);
    tick();
    check("acc_res",    32'(res_data), 32'h5A);
    tick();

    // Reset while in EXEC aborts and clears the accumulator.
    cmd_valid = 1'b1; cmd_op = OP_D2; cmd_a = 8'h11; cmd_b = 8'h22;
    tick();
    cmd_valid = 1'b0;
    check("r_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("r_busy",      32'(busy),      32'd0);
    check("r_res_valid", 32'(res_valid), 32'd0);
    check("r_cmd_ready", 32'(cmd_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd_op = OP_D0; cmd_a = 8'hFF; cmd_b = 8'h00; cmd_acc = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_acc = 1'b0;
    check("r_acc_zero", 32'(alu_a), 32'h00);
    tick();
    tick();

    // SETTLE=3: three EXEC cycles with stable select, then a zero result.
    tbl3[1] = 8'h00;
    cmd_valid3 = 1'b1; cmd_op3 = OP_D1; cmd_a3 = 8'h33; cmd_b3 = 8'h44;
    tick();
    cmd_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s3_mux_sel", 32'(mux_sel3),  32'd1);
      check("s3_not_yet", 32'(res_valid3), 32'd0);
      check("s3_busy",    32'(busy3),      32'd1);
      tick();
    end
    check("s3_res_valid", 32'(res_valid3), 32'd1);
    check("s3_res_data",  32'(res_data3),  32'h00);
    check("s3_zero",      32'(res_zero3),  32'd1);
    check("s3_neg",       32'(res_neg3),   32'd0);
    tick();
    check("s3_idle",      32'(cmd_ready3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
